stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control and timing sequencer for the lab3 stopwatch. Conditions the four raw board inputs (SEL, ADJ, PAUSE, RESET buttons/switches), runs the run/pause state machine, and derives every timing strobe the minutes:seconds counter datapath and the 7-segment display driver consume. The counter datapath holds no timing logic of its own: it advances only on this block's single-cycle enable pulses and clears only on `clr`.

## Interface
- `TICK4_DIV`, 25_000_000: clk cycles per 4 Hz base tick (100 MHz board clock).
- `SCAN_DIV`, 100_000: clk cycles per display digit-scan tick (1 kHz).
- `DB_CYCLES`, 1_000_000: consecutive stable cycles required to accept an input change (10 ms).

- `clk`  in  1  system clock, 100 MHz
- `RESET_N`  in  1  asynchronous, active-low block reset
- `SEL`  in  1  raw switch; 0 = adjust minutes, 1 = adjust seconds
- `ADJ`  in  1  raw switch; 1 = adjust mode
- `PAUSE`  in  1  raw button; each press toggles run/pause
- `RESET`  in  1  raw button; each press clears the time
- `cnt_en`  out  1  1 Hz single-cycle pulse; seconds counter advances
- `adj_min_en`  out  1  2 Hz single-cycle pulse; minutes field increments
- `adj_sec_en`  out  1  2 Hz single-cycle pulse; seconds field increments
- `clr`  out  1  single-cycle synchronous clear to the counters
- `blink`  out  1  2 Hz square wave; display blanks the selected field while low and `adj_mode`=1
- `scan_tick`  out  1  single-cycle digit-mux advance pulse
- `adj_mode`  out  1  debounced ADJ level
- `paused`  out  1  1 when state is PAUSED

## Operation
- Input conditioning: each raw input passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized value has differed from it for DB_CYCLES consecutive cycles.
  - A rise pulse fires on the cycle the debounced level goes 0→1.
- Prescaler: a free-running counter 0..TICK4_DIV-1 produces `t4` on wrap. A 2-bit phase counter advances on each `t4`.
  - `t2` = `t4` when phase[0]=1.
  - `t1` = `t4` when phase=3.
  - `blink` = phase[0] registered, inverted on every `t4`.
  - Pause and ADJ do not stop the prescaler.
- Scan counter: free-running 0..SCAN_DIV-1; `scan_tick` fires on wrap. Unaffected by everything except RESET_N.
- State machine (states RUNNING, PAUSED):
  - Reset state is RUNNING.
  - PAUSE rise pulse toggles RUNNING↔PAUSED. This is also accepted while in adjust mode and takes effect when adjust mode ends.
  - RESET rise pulse forces RUNNING.
- Output rules:
  - `cnt_en` = `t1` && RUNNING && !adj_mode.
  - `adj_min_en` = `t2` && adj_mode && !sel_db.
  - `adj_sec_en` = `t2` && adj_mode && sel_db.
- Clear: a RESET rise pulse asserts `clr` for exactly one cycle and, in the same cycle, zeroes the prescaler and phase counter. The next `cnt_en` therefore arrives a full second later.
- All outputs are registered.

## Timing
- Reset values while RESET_N=0: all pulses 0, `blink`=0, `adj_mode`=0, `paused`=0, debounced levels 0, all counters 0.
- Input-to-event latency: 2 sync cycles + DB_CYCLES + 1 register cycle.
  - A clean press yields exactly one rise pulse.
  - Glitches shorter than DB_CYCLES yield none.
- `clr` and the state change both appear on the cycle after the RESET rise pulse.
- Simultaneous events:
  - RESET and PAUSE pulses in the same cycle: RESET wins, the PAUSE toggle is discarded, the state ends RUNNING.
  - `clr` coincident with a `t1`/`t2`: `clr` wins, all enables are suppressed that cycle.
  - ADJ or SEL changing mid-period: gating uses the debounced level on the tick cycle. There are no partial pulses.
- Wrap-around: the prescaler wraps at TICK4_DIV-1 and the phase counter wraps 3→0 without a gap. `cnt_en` period is exactly 4·TICK4_DIV cycles.
- RESET_N asserted mid-operation: every register clears immediately, with no pulse emitted.

## Structure
- Package `stopwatch_pkg` holds:
  - the state encoding (RUNNING=0, PAUSED=1);
  - default parameter constants;
  - the SEL encoding constants.
- Sub-module `btn_debounce` (parameter DB_CYCLES; ports clk, RESET_N, din, level, rise) contains the synchronizer, stability counter and edge detect.
  - Instantiated four times: SEL, ADJ, PAUSE, RESET.
- The prescaler, scan counter and FSM stay in the top level.

## Test plan
Parameters for all scenarios: TICK4_DIV=10, SCAN_DIV=7, DB_CYCLES=4.

1. Reset then idle 200 cycles.
   - Required: `cnt_en` every 40 cycles, first at cycle 40 after RESET_N release.
   - Required: `scan_tick` every 7 cycles; `paused`=0.
2. PAUSE held 10 cycles.
   - Required: `paused`=1 within 7 cycles of the press; no `cnt_en` afterwards.
   - A second press returns to `paused`=0.
3. PAUSE pulsed 2 cycles.
   - Required: no state change.
4. ADJ=1, SEL=0 for 100 cycles.
   - Required: `adj_min_en` every 20 cycles; `adj_sec_en`=0 and `cnt_en`=0.
   - SEL→1: `adj_sec_en` replaces it after the debounce latency.
5. RESET and PAUSE pressed in the same cycle while PAUSED.
   - Required: one `clr` pulse; `paused`=0; next `cnt_en` 40 cycles after `clr`.
6. RESET_N dropped mid-period while ADJ=1.
   - Required: all outputs 0 immediately.
   - After release: `adj_mode` returns to 1 within 7 cycles.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control/timing block.
package stopwatch_pkg;

    // Run/pause state encoding.
    typedef enum logic {
        StRunning = 1'b0,
        StPaused  = 1'b1
    } sw_state_e;

    // Board defaults for a 100 MHz clock.
    localparam int unsigned DefTick4Div = 25_000_000;  // 4 Hz base tick
    localparam int unsigned DefScanDiv  = 100_000;     // 1 kHz digit scan
    localparam int unsigned DefDbCycles = 1_000_000;   // 10 ms debounce

    // SEL switch meaning.
    localparam logic SelMinutes = 1'b0;
    localparam logic SelSeconds = 1'b1;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board-side bundle: raw inputs into the controller, strobes out to datapath/display.
interface stopwatch_ctrl_if;

    logic SEL;
    logic ADJ;
    logic PAUSE;
    logic RESET;

    logic cnt_en;
    logic adj_min_en;
    logic adj_sec_en;
    logic clr;
    logic blink;
    logic scan_tick;
    logic adj_mode;
    logic paused;

    // Board / test side: drives the switches and buttons, consumes the strobes.
    modport master (
        output SEL, ADJ, PAUSE, RESET,
        input  cnt_en, adj_min_en, adj_sec_en, clr, blink, scan_tick, adj_mode, paused
    );

    // Controller side.
    modport slave (
        input  SEL, ADJ, PAUSE, RESET,
        output cnt_en, adj_min_en, adj_sec_en, clr, blink, scan_tick, adj_mode, paused
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge detect for one raw input.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DefDbCycles
) (
    input  logic clk,
    input  logic RESET_N,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Accept the synced value once it has disagreed with the level DB_CYCLES cycles in a row.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Synchronizer and debounce state.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timing sequencer: input conditioning, run/pause FSM, prescaler,
// display scan tick and all registered enable strobes for the counter datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK4_DIV = DefTick4Div,
    parameter int unsigned SCAN_DIV  = DefScanDiv,
    parameter int unsigned DB_CYCLES = DefDbCycles
) (
    input logic             clk,
    input logic             RESET_N,
    stopwatch_ctrl_if.slave bus
);

    localparam int unsigned PreW  = (TICK4_DIV > 1) ? $clog2(TICK4_DIV) : 1;
    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PreW-1:0]  PreMax  = PreW'(TICK4_DIV - 1);
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

    logic sel_lvl, adj_lvl, pause_rise, reset_rise;
    logic sel_rise_unused, adj_rise_unused, pause_lvl_unused, reset_lvl_unused;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .clk     (clk),
        .RESET_N (RESET_N),
        .din     (bus.SEL),
        .level   (sel_lvl),
        .rise    (sel_rise_unused)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
        .clk     (clk),
        .RESET_N (RESET_N),
        .din     (bus.ADJ),
        .level   (adj_lvl),
        .rise    (adj_rise_unused)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk     (clk),
        .RESET_N (RESET_N),
        .din     (bus.PAUSE),
        .level   (pause_lvl_unused),
        .rise    (pause_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
        .clk     (clk),
        .RESET_N (RESET_N),
        .din     (bus.RESET),
        .level   (reset_lvl_unused),
        .rise    (reset_rise)
    );

    // ---------------- Prescaler: 4 Hz tick, 2-bit phase, blink ----------------
    logic [PreW-1:0] pre_q, pre_d;
    logic [1:0]      phase_q, phase_d;
    logic            blink_q, blink_d;
    logic            t4, t2, t1;

    // Free-running divider; a RESET press restarts it so the next second is a full one.
    always_comb begin
        t4      = (pre_q == PreMax);
        pre_d   = t4 ? '0 : pre_q + PreW'(1);
        phase_d = t4 ? phase_q + 2'd1 : phase_q;
        blink_d = t4 ? ~blink_q : blink_q;
        if (reset_rise) begin
            pre_d   = '0;
            phase_d = 2'd0;
            blink_d = 1'b0;
        end
    end

    assign t2 = t4 & phase_q[0];
    assign t1 = t4 & (phase_q == 2'd3);

    // Prescaler registers.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q   <= '0;
            phase_q <= 2'd0;
            blink_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
        end
    end

    // ---------------- Display scan counter ----------------
    logic [ScanW-1:0] scan_q, scan_d;
    logic             scan_tick_q, scan_tick_d;

    // Free-running; only RESET_N touches it.
    always_comb begin
        scan_tick_d = (scan_q == ScanMax);
        scan_d      = scan_tick_d ? '0 : scan_q + ScanW'(1);
    end

    // Scan registers.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_q      <= '0;
            scan_tick_q <= 1'b0;
        end else begin
            scan_q      <= scan_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    // ---------------- Run/pause FSM ----------------
    sw_state_e state_q, state_d;
    logic      cnt_en_q, cnt_en_d;
    logic      adj_min_en_q, adj_min_en_d;
    logic      adj_sec_en_q, adj_sec_en_d;
    logic      clr_q, clr_d;

    // State register.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StRunning;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: RESET forces RUNNING and swallows a coincident PAUSE toggle.
    // PAUSE toggles even in adjust mode; cnt_en gating makes it take effect afterwards.
    always_comb begin
        state_d = state_q;
        if (reset_rise) begin
            state_d = StRunning;
        end else if (pause_rise) begin
            state_d = (state_q == StRunning) ? StPaused : StRunning;
        end
    end

    // Output decode: enables gated by levels on the tick cycle; a clear suppresses them.
    always_comb begin
        clr_d        = reset_rise;
        cnt_en_d     = t1 && (state_q == StRunning) && !adj_lvl && !reset_rise;
        adj_min_en_d = t2 && adj_lvl && (sel_lvl == SelMinutes) && !reset_rise;
        adj_sec_en_d = t2 && adj_lvl && (sel_lvl == SelSeconds) && !reset_rise;
    end

    // Registered strobes.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            clr_q        <= 1'b0;
            cnt_en_q     <= 1'b0;
            adj_min_en_q <= 1'b0;
            adj_sec_en_q <= 1'b0;
        end else begin
            clr_q        <= clr_d;
            cnt_en_q     <= cnt_en_d;
            adj_min_en_q <= adj_min_en_d;
            adj_sec_en_q <= adj_sec_en_d;
        end
    end

    assign bus.cnt_en     = cnt_en_q;
    assign bus.adj_min_en = adj_min_en_q;
    assign bus.adj_sec_en = adj_sec_en_q;
    assign bus.clr        = clr_q;
    assign bus.blink      = blink_q;
    assign bus.scan_tick  = scan_tick_q;
    assign bus.adj_mode   = adj_lvl;
    assign bus.paused     = (state_q == StPaused);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK4_DIV=10, SCAN_DIV=7, DB_CYCLES=4.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
// Press-to-event latency is 2 sync + 4 debounce + 1 register = 7 edges for FSM/clr,
// and 6 edges for a debounced level (adj_mode).
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .TICK4_DIV (10),
        .SCAN_DIV  (7),
        .DB_CYCLES (4)
    ) dut (
        .clk     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.cnt_en, bus.adj_min_en, bus.adj_sec_en, bus.clr,
                bus.blink, bus.scan_tick, bus.adj_mode, bus.paused};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int first, n_cnt, n_min, n_sec, n_clr, n_p, prev, bad_gap;
        int bad_cnt, bad_scan, bad_blink, bad_misc, lat, clr_at;
        logic p_at_clr, b_at_clr, e_at_clr;

        // ---- 1: reset, then idle 200 cycles ----
        rst_n = 1'b0;
        bus.SEL = 1'b0; bus.ADJ = 1'b0; bus.PAUSE = 1'b0; bus.RESET = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        first = -1; n_cnt = 0; bad_cnt = 0; bad_scan = 0; bad_blink = 0; bad_misc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.cnt_en === 1'b1) begin
                n_cnt++;
                if (first < 0) first = k;
            end
            if (bus.cnt_en !== (k % 40 == 0)) bad_cnt++;
            if (bus.scan_tick !== (k % 7 == 0)) bad_scan++;
            if (bus.blink !== 1'((k / 10) % 2)) bad_blink++;
            if (bus.paused !== 1'b0 || bus.adj_min_en !== 1'b0 || bus.adj_sec_en !== 1'b0 ||
                bus.clr !== 1'b0) bad_misc++;
        end
        chk("cnt_en_first", first, 40);
        chk("cnt_en_count", n_cnt, 5);
        chk("cnt_en_pattern_errs", bad_cnt, 0);
        chk("scan_tick_pattern_errs", bad_scan, 0);
        chk("blink_pattern_errs", bad_blink, 0);
        chk("idle_other_outputs_errs", bad_misc, 0);

        // ---- 2: PAUSE held 10 cycles pauses; a second press resumes ----
        bus.PAUSE = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.paused === 1'b1 && lat < 0) lat = i;
        end
        bus.PAUSE = 1'b0;
        chk("pause_latency", lat, 7);
        n_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.cnt_en === 1'b1) n_cnt++;
        end
        chk("paused_no_cnt_en", n_cnt, 0);
        chk("paused_still_set", bus.paused, 1);
        bus.PAUSE = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.paused === 1'b0 && lat < 0) lat = i;
        end
        bus.PAUSE = 1'b0;
        chk("resume_latency", lat, 7);
        n_cnt = 0;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            if (bus.cnt_en === 1'b1) n_cnt++;
        end
        chk("resumed_cnt_en_count", n_cnt, 1);

        // ---- 3: 2-cycle glitch on PAUSE is ignored ----
        bus.PAUSE = 1'b1;
        repeat (2) @(negedge clk);
        bus.PAUSE = 1'b0;
        n_p = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.paused !== 1'b0) n_p++;
        end
        chk("glitch_no_toggle", n_p, 0);

        // ---- 4: adjust mode, minutes then seconds ----
        bus.ADJ = 1'b1; bus.SEL = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.adj_mode === 1'b1 && lat < 0) lat = i;
        end
        chk("adj_mode_latency", lat, 6);
        n_min = 0; n_sec = 0; n_cnt = 0; prev = -1; bad_gap = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.adj_min_en === 1'b1) begin
                n_min++;
                if (prev >= 0 && i - prev != 20) bad_gap++;
                prev = i;
            end
            if (bus.adj_sec_en === 1'b1) n_sec++;
            if (bus.cnt_en === 1'b1) n_cnt++;
        end
        chk("adj_min_count", n_min, 5);
        chk("adj_min_gap_errs", bad_gap, 0);
        chk("adj_min_no_sec", n_sec, 0);
        chk("adj_min_no_cnt_en", n_cnt, 0);
        bus.SEL = 1'b1;
        repeat (7) @(negedge clk);
        n_min = 0; n_sec = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.adj_min_en === 1'b1) n_min++;
            if (bus.adj_sec_en === 1'b1) n_sec++;
        end
        chk("adj_sec_count", n_sec, 3);
        chk("adj_sec_no_min", n_min, 0);
        bus.ADJ = 1'b0; bus.SEL = 1'b0;
        repeat (10) @(negedge clk);
        chk("adj_mode_cleared", bus.adj_mode, 0);

        // ---- 5: RESET and PAUSE together while PAUSED ----
        bus.PAUSE = 1'b1;
        repeat (10) @(negedge clk);
        bus.PAUSE = 1'b0;
        repeat (10) @(negedge clk);
        chk("paused_before_reset", bus.paused, 1);
        bus.RESET = 1'b1; bus.PAUSE = 1'b1;
        n_clr = 0; clr_at = -1; first = -1;
        p_at_clr = 1'bx; b_at_clr = 1'bx; e_at_clr = 1'bx;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 10) begin
                bus.RESET = 1'b0; bus.PAUSE = 1'b0;
            end
            if (bus.clr === 1'b1) begin
                n_clr++;
                if (clr_at < 0) begin
                    clr_at = i;
                    p_at_clr = bus.paused;
                    b_at_clr = bus.blink;
                    e_at_clr = bus.cnt_en;
                end
            end
            if (bus.cnt_en === 1'b1 && clr_at >= 0 && first < 0) first = i - clr_at;
        end
        chk("clr_pulse_count", n_clr, 1);
        chk("clr_latency", clr_at, 7);
        chk("clr_state_running", p_at_clr, 0);
        chk("clr_blink_zero", b_at_clr, 0);
        chk("clr_no_cnt_en", e_at_clr, 0);
        chk("cnt_en_after_clr", first, 40);
        chk("running_after_reset", bus.paused, 0);

        // ---- 6: RESET_N dropped mid-period in adjust mode ----
        bus.ADJ = 1'b1;
        repeat (10) @(negedge clk);
        repeat (13) @(negedge clk);
        chk("adj_before_rst", bus.adj_mode, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", outs(), 0);
        repeat (3) @(negedge clk);
        chk("held_reset_outputs", outs(), 0);
        rst_n = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.adj_mode === 1'b1 && lat < 0) lat = i;
        end
        chk("adj_mode_after_rst", lat, 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
